// File: rtl/fabric_pe_load_tracked.sv
// Load adapter PE: joins address + control token into a memory request and re-tags in-order responses from a tag queue; zero-latency issue, 1-cycle response path.
// Issue stalls when QUEUE_DEPTH loads are outstanding (unless a pop frees a slot); optional perf counters under `FABRIC_PE_LOAD_TRACKED_PERF_EN.
module fabric_pe_load_tracked #(
    parameter  int ELEM_WIDTH  = 32,
    parameter  int ADDR_WIDTH  = 64,
    parameter  int TAG_WIDTH   = 0,
    parameter  int HW_TYPE     = 0,
    parameter  int QUEUE_DEPTH = 4,
    localparam int CNT_W       = $clog2(QUEUE_DEPTH + 1),
    localparam int PTR_W       = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1,
    localparam int TW          = (TAG_WIDTH > 0) ? TAG_WIDTH : 1,
    localparam int IN2_W       = (HW_TYPE == 1) ? TW : 1,
    localparam int CFG_W       = (HW_TYPE == 0 && TAG_WIDTH > 0) ? TAG_WIDTH : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in0_valid,
    output logic                            in0_ready,
    input  logic [ADDR_WIDTH+TAG_WIDTH-1:0] in0_data,
    input  logic                            in1_valid,
    output logic                            in1_ready,
    input  logic [ELEM_WIDTH+TAG_WIDTH-1:0] in1_data,
    input  logic                            in2_valid,
    output logic                            in2_ready,
    input  logic [IN2_W-1:0]                in2_data,
    output logic                            out0_valid,
    input  logic                            out0_ready,
    output logic [ADDR_WIDTH+TAG_WIDTH-1:0] out0_data,
    output logic                            out1_valid,
    input  logic                            out1_ready,
    output logic [ELEM_WIDTH+TAG_WIDTH-1:0] out1_data,
    input  logic [CFG_W-1:0]                cfg_data,
`ifdef FABRIC_PE_LOAD_TRACKED_PERF_EN
    output logic [31:0]                     perf_issue_cnt,
    output logic [31:0]                     perf_stall_cnt,
    output logic [31:0]                     perf_mismatch_cnt,
`endif
    output logic [CNT_W-1:0]                outstanding
);
    localparam int OW = ELEM_WIDTH + TAG_WIDTH;

    logic [TW-1:0]    in0_tag, issue_tag, pop_tag;
    logic             match, slot, req, issue, pop;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             out1_valid_q, out1_valid_d;
    logic [OW-1:0]    out1_data_q, out1_data_d;
    logic             unused_bits;

    // Tag fields of in1 (and whichever of in2/cfg the mode ignores) are don't-care.
    assign unused_bits = ^{in1_data, in2_data, cfg_data, in0_data};

    generate
        if (TAG_WIDTH > 0) begin : g_tag
            logic [TW-1:0] tag_q [QUEUE_DEPTH];
            always_ff @(posedge clk) begin
                if (issue) tag_q[wr_ptr_q] <= issue_tag;
            end
            assign in0_tag   = in0_data[ADDR_WIDTH +: TW];
            assign pop_tag   = tag_q[rd_ptr_q];
            assign out0_data = {issue_tag, in0_data[ADDR_WIDTH-1:0]};
        end else begin : g_notag
            assign in0_tag   = '0;
            assign pop_tag   = '0;
            assign out0_data = in0_data;
        end

        if (HW_TYPE == 1) begin : g_transparent
            assign issue_tag = in0_tag;
            assign match     = (in0_tag == in2_data);
        end else begin : g_overwrite
            assign issue_tag = TW'(cfg_data);
            assign match     = 1'b1;
        end
    endgenerate

    // A pop in the same cycle frees a slot, so a full queue still issues.
    assign in1_ready  = (cnt_q != '0) & (~out1_valid_q | out1_ready);
    assign pop        = in1_valid & in1_ready;
    assign slot       = (cnt_q < CNT_W'(QUEUE_DEPTH)) | pop;
    assign req        = in0_valid & in2_valid & match;
    assign out0_valid = req & slot;
    assign issue      = out0_valid & out0_ready;
    assign in0_ready  = issue;
    assign in2_ready  = issue;

    always_comb begin
        cnt_d        = cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        out1_valid_d = out1_valid_q;
        out1_data_d  = out1_data_q;
        if (issue & ~pop) cnt_d = cnt_q + CNT_W'(1);
        if (pop & ~issue) cnt_d = cnt_q - CNT_W'(1);
        if (issue) wr_ptr_d = (wr_ptr_q == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        if (pop) begin
            rd_ptr_d     = (rd_ptr_q == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            out1_valid_d = 1'b1;
            if (TAG_WIDTH > 0) out1_data_d = OW'({pop_tag, in1_data[ELEM_WIDTH-1:0]});
            else               out1_data_d = OW'(in1_data[ELEM_WIDTH-1:0]);
        end else if (out1_ready) begin
            out1_valid_d = 1'b0;
            out1_data_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            out1_valid_q <= 1'b0;
            out1_data_q  <= '0;
        end else begin
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            out1_valid_q <= out1_valid_d;
            out1_data_q  <= out1_data_d;
        end
    end

    assign outstanding = cnt_q;
    assign out1_valid  = out1_valid_q;
    assign out1_data   = out1_data_q;

`ifdef FABRIC_PE_LOAD_TRACKED_PERF_EN
    logic [31:0] perf_issue_q, perf_stall_q, perf_mismatch_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_q    <= '0;
            perf_stall_q    <= '0;
            perf_mismatch_q <= '0;
        end else begin
            if (issue)                            perf_issue_q    <= perf_issue_q + 32'd1;
            if (in0_valid & in2_valid & ~issue)   perf_stall_q    <= perf_stall_q + 32'd1;
            if (in0_valid & in2_valid & ~match)   perf_mismatch_q <= perf_mismatch_q + 32'd1;
        end
    end

    assign perf_issue_cnt    = perf_issue_q;
    assign perf_stall_cnt    = perf_stall_q;
    assign perf_mismatch_cnt = perf_mismatch_q;
`endif

endmodule
